pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised elastic pipeline register replacing fixed per-stage fd/de/ew registers.
//  Holds up to DEPTH words between two stages under valid/ready handshake; empty slots read as BUBBLE.
//  Flush discards all held words (branch/jump kill), so stages stall and kill without a shared update code.
// PARAMETERS
//  WIDTH   32     payload bits per entry (packed stage bundle)
//  DEPTH   2      entries, 1..8; need not be a power of two
//  BUBBLE  32'h1  value on out_data when empty (NOP encoding); zero-extended/truncated to WIDTH
// PORTS
//  clk        in   1            clock; all state updates on posedge
//  rst        in   1            synchronous reset, active-high
//  flush      in   1            discard all entries and any same-cycle push
//  in_valid   in   1            upstream word present
//  in_ready   out  1            space available (registered, = count < DEPTH)
//  in_data    in   WIDTH        upstream payload
//  out_valid  out  1            head entry present (count != 0)
//  out_ready  in   1            downstream accepts head
//  out_data   out  WIDTH        head payload; BUBBLE when out_valid=0
//  count      out  CW           occupancy, CW = $clog2(DEPTH+1)
// BEHAVIOUR
//  Reset (rst=1 at posedge): count=0, rd/wr pointers=0, out_valid=0, out_data=BUBBLE, in_ready=1.
//  push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
//  Latency: word pushed at posedge N appears on out_data after posedge N (no same-cycle bypass).
//  in_ready depends only on registered count; no combinational path from out_ready to in_ready.
//  Full (count==DEPTH): in_ready=0; in_valid ignored; pop still allowed, in_ready rises next cycle.
//  Empty (count==0): out_valid=0, out_data=BUBBLE; out_ready ignored.
//  Push+pop same cycle: count unchanged, both pointers advance; at DEPTH=1 only legal when count=1
//   is not full-blocked, i.e. push waits one cycle (in_ready registered).
//  Pointers wrap explicitly: ptr==DEPTH-1 -> 0 (valid for non-power-of-two DEPTH).
//  FIFO order strict; out_data stable while out_valid & ~out_ready.
//  flush=1: next cycle count=0, pointers=0, out_valid=0; flush dominates push and pop that cycle.
//  rst dominates flush; rst mid-transfer loses all entries, no partial state retained.
//  Storage contents are not cleared by flush/reset; only output muxing hides them.
// CONFIGURATION
//  Macro PIPE_STAGE_STATS_EN:
//   defined: extra outputs stall_cycles[31:0] (count of cycles out_valid & ~out_ready) and
//    flush_drops[31:0] (sum of count at each flush, plus 1 if a push was killed); both saturate at
//    32'hFFFF_FFFF, reset to 0 by rst, not cleared by flush.
//   undefined: ports and counters absent; remaining behaviour identical.
// STRUCTURE
//  Package pipe_pkg: BUBBLE_INSTR constant (32'h1), function cnt_w(depth) = $clog2(depth+1),
//   stage-bundle typedefs (fd_bundle_t, de_bundle_t, ew_bundle_t) so callers set WIDTH=$bits(t).
//  Sub-module pipe_buf_mem: DEPTH x WIDTH register array, write port (we, waddr, wdata),
//   async read port (raddr -> rdata); pipe_stage_buf owns pointers, count, handshake, flush.
// TESTING
//  1 rst 2 cycles, no stimulus -> out_valid=0, out_data=32'h1, count=0, in_ready=1.
//  2 DEPTH=2, push A=0x11,B=0x22 with out_ready=0 -> count=2, in_ready=0, out_data=0x11 held;
//    third push 0x33 ignored; then out_ready=1 two cycles -> 0x11,0x22 out in order, count=0.
//  3 Steady streaming in_valid=out_ready=1, 8 words 0..7 -> each emerges one cycle after push, no
//    gaps after fill, count stays 1.
//  4 count=2 plus in_valid=1 and flush=1 same cycle -> next cycle count=0, out_data=32'h1;
//    with PIPE_STAGE_STATS_EN flush_drops=2 (full, push blocked), stall_cycles unchanged by flush.
//  5 DEPTH=3 (non-power-of-two): 10 push/pop interleavings -> pointers wrap 2->0, order preserved.
//  6 rst asserted while count=1 and flush=1 -> count=0; stats counters 0 (rst dominates).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants, helpers and stage-bundle types for the elastic pipeline buffer.
// Callers size a buffer from a bundle type, e.g. WIDTH = $bits(fd_bundle_t).
package pipe_pkg;

    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0001;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return sum[31:0];
        end
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fd_bundle_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } de_bundle_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
    } ew_bundle_t;

endpackage

// File: rtl/pipe_buf_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are never cleared; the owner hides stale slots by output muxing.
module pipe_buf_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int PW    = 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    // Storage write
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline register holding up to DEPTH words; empty reads as BUBBLE.
// Optional PIPE_STAGE_STATS_EN adds saturating stall_cycles / flush_drops counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int          WIDTH  = 32,
    parameter int          DEPTH  = 2,
    parameter logic [31:0] BUBBLE = BUBBLE_INSTR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [cnt_w(DEPTH)-1:0]    count
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [31:0]                flush_drops
`endif
);

    localparam int               CW       = cnt_w(DEPTH);
    localparam int               PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] BUBBLE_W = WIDTH'(BUBBLE);

    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_rdata;

    // Explicit wrap keeps non-power-of-two depths in range
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign w_push = in_valid & r_in_ready & ~flush;
    assign w_pop  = r_out_valid & out_ready & ~flush;

    // Next occupancy from the accepted handshakes
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, occupancy and registered handshake flags
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count     <= {CW{1'b0}};
            r_wr_ptr    <= {PW{1'b0}};
            r_rd_ptr    <= {PW{1'b0}};
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != {CW{1'b0}});
            r_in_ready  <= (w_count_nxt < CW'(DEPTH));
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
        end
    end

    pipe_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (in_data),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_valid ? w_rdata : BUBBLE_W;
    assign count     = r_count;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_drops;
    logic        w_kill;

    assign w_kill = in_valid & r_in_ready & flush;

    // Saturating stall and flush-drop counters; flush does not clear them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 32'h0000_0000;
            r_flush_drops  <= 32'h0000_0000;
        end else begin
            if (r_out_valid && !out_ready) begin
                r_stall_cycles <= sat_add32(r_stall_cycles, 32'h0000_0001);
            end
            if (flush) begin
                r_flush_drops <= sat_add32(r_flush_drops, 32'(r_count) + 32'(w_kill));
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_drops  = r_flush_drops;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed scoreboard bench for pipe_stage_buf at DEPTH=2 and DEPTH=3.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2;
    logic [31:0] in_data2, out_data2;
    logic [1:0]  count2;
    logic        flush3, in_valid3, in_ready3, out_valid3, out_ready3;
    logic [31:0] in_data3, out_data3;
    logic [1:0]  count3;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall2, drops2, stall3, drops3;
    logic [31:0] exp_stall2, exp_drops2;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb2[$];
    logic [31:0] sb3[$];

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .count(count2)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cycles(stall2), .flush_drops(drops2)
`endif
    );

    pipe_stage_buf #(.WIDTH(32), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush3),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .count(count3)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cycles(stall3), .flush_drops(drops3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle on the DEPTH=2 instance: check outputs against the model, clock, update model
    task automatic step2(input logic v, input logic [31:0] d, input logic r, input logic f);
        logic pu, po;
        int   sz;
        in_valid2 = v; in_data2 = d; out_ready2 = r; flush2 = f;
        sz = sb2.size();
        check("d2_count", {30'd0, count2}, sz);
        check("d2_out_valid", {31'd0, out_valid2}, {31'd0, sz != 0});
        check("d2_in_ready", {31'd0, in_ready2}, {31'd0, sz < 2});
        check("d2_out_data", out_data2, (sz != 0) ? sb2[0] : 32'h0000_0001);
        pu = v && (sz < 2) && !f;
        po = r && (sz != 0) && !f;
`ifdef PIPE_STAGE_STATS_EN
        check("d2_stall_cycles", stall2, exp_stall2);
        check("d2_flush_drops", drops2, exp_drops2);
        if (sz != 0 && !r) exp_stall2++;
        if (f) exp_drops2 += sz + ((v && sz < 2) ? 1 : 0);
`endif
        @(posedge clk);
        if (f) begin
            sb2.delete();
        end else begin
            if (po) void'(sb2.pop_front());
            if (pu) sb2.push_back(d);
        end
        #1;
    endtask

    // One cycle on the DEPTH=3 instance
    task automatic step3(input logic v, input logic [31:0] d, input logic r);
        logic pu, po;
        int   sz;
        in_valid3 = v; in_data3 = d; out_ready3 = r; flush3 = 1'b0;
        sz = sb3.size();
        check("d3_count", {30'd0, count3}, sz);
        check("d3_in_ready", {31'd0, in_ready3}, {31'd0, sz < 3});
        check("d3_out_data", out_data3, (sz != 0) ? sb3[0] : 32'h0000_0001);
        pu = v && (sz < 3);
        po = r && (sz != 0);
        @(posedge clk);
        if (po) void'(sb3.pop_front());
        if (pu) sb3.push_back(d);
        #1;
    endtask

    task automatic do_reset(input logic f2);
        rst = 1'b1; flush2 = f2;
        in_valid2 = 1'b0; out_ready2 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0; flush3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; flush2 = 1'b0;
        sb2.delete();
        sb3.delete();
`ifdef PIPE_STAGE_STATS_EN
        exp_stall2 = 32'h0; exp_drops2 = 32'h0;
`endif
    endtask

    initial begin
        in_data2 = 32'h0; in_data3 = 32'h0;
        do_reset(1'b0);
        // Reset state
        check("rst_out_valid", {31'd0, out_valid2}, 32'h0);
        check("rst_out_data", out_data2, 32'h0000_0001);
        check("rst_count", {30'd0, count2}, 32'h0);
        check("rst_in_ready", {31'd0, in_ready2}, 32'h1);

        // Fill to full, blocked push, then ordered drain
        step2(1'b1, 32'h11, 1'b0, 1'b0);
        step2(1'b1, 32'h22, 1'b0, 1'b0);
        step2(1'b1, 32'h33, 1'b0, 1'b0);
        step2(1'b0, 32'h0, 1'b0, 1'b0);
        step2(1'b0, 32'h0, 1'b1, 1'b0);
        step2(1'b0, 32'h0, 1'b1, 1'b0);
        step2(1'b0, 32'h0, 1'b1, 1'b0);

        // Steady streaming
        for (int i = 0; i < 8; i++) step2(1'b1, i, 1'b1, 1'b0);
        step2(1'b0, 32'h0, 1'b1, 1'b0);
        step2(1'b0, 32'h0, 1'b0, 1'b0);

        // Flush while full with a blocked push
        do_reset(1'b0);
        step2(1'b1, 32'hA1, 1'b0, 1'b0);
        step2(1'b1, 32'hA2, 1'b0, 1'b0);
        step2(1'b1, 32'hA3, 1'b0, 1'b1);
        step2(1'b0, 32'h0, 1'b0, 1'b0);
        // Flush from one entry with a push that gets killed
        step2(1'b1, 32'hB1, 1'b0, 1'b0);
        step2(1'b1, 32'hB2, 1'b1, 1'b1);
        step2(1'b1, 32'hB3, 1'b1, 1'b0);
        step2(1'b0, 32'h0, 1'b1, 1'b0);
        step2(1'b0, 32'h0, 1'b0, 1'b0);

        // Non-power-of-two depth wrap with mixed push/pop patterns
        for (int i = 0; i < 24; i++) begin
            step3((i % 4) != 3, 32'h100 + i, (i % 3) != 0 && i > 4);
        end
        for (int i = 0; i < 4; i++) step3(1'b0, 32'h0, 1'b1);

        // Reset dominates a same-cycle flush with one entry held
        step2(1'b1, 32'hC1, 1'b0, 1'b0);
        do_reset(1'b1);
        check("rstflush_count", {30'd0, count2}, 32'h0);
        check("rstflush_out_data", out_data2, 32'h0000_0001);
`ifdef PIPE_STAGE_STATS_EN
        check("rstflush_stall", stall2, 32'h0);
        check("rstflush_drops", drops2, 32'h0);
`endif
        step2(1'b0, 32'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
